// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with one outstanding transaction.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_start_if;
    logic w_start_dm;
    logic w_ack_if;
    logic w_ack_dm;
    logic w_starved;

    logic              r_if_gnt;
    logic              r_dm_gnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;

    if (STARVE_MAX < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("mem_arbiter: STARVE_MAX must be >= 1 and DATA_W a multiple of 8");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    // Counts data grants won while fetch was left waiting; saturates at STARVE_MAX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (w_start_if) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (w_start_dm && i_if_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign w_starved = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transaction start/finish strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start_if  = 1'b0;
        w_start_dm  = 1'b0;
        w_ack_if    = 1'b0;
        w_ack_dm    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_dm_req && !(w_starved && i_if_req)) begin
                    w_start_dm  = 1'b1;
                    w_state_nxt = ST_DM_BUSY;
                end else if (i_if_req) begin
                    w_start_if  = 1'b1;
                    w_state_nxt = ST_IF_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IF_BUSY: begin
                if (i_mem_ack) begin
                    w_ack_if    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IF_BUSY;
                end
            end
            ST_DM_BUSY: begin
                if (i_mem_ack) begin
                    w_ack_dm    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DM_BUSY;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory port capture, grant pulses and read-data capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_be    <= {BE_W{1'b0}};
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rdata  <= {DATA_W{1'b0}};
            r_dm_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_if_gnt <= w_ack_if;
            r_dm_gnt <= w_ack_dm;
            if (w_start_dm) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= i_dm_we;
                r_mem_addr  <= i_dm_addr;
                r_mem_wdata <= i_dm_wdata;
                r_mem_be    <= i_dm_be;
            end else if (w_start_if) begin
                // Fetches are always full-word reads.
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= i_if_addr;
                r_mem_wdata <= {DATA_W{1'b0}};
                r_mem_be    <= {BE_W{1'b1}};
            end else if (w_ack_if || w_ack_dm) begin
                r_mem_req <= 1'b0;
            end
            if (w_ack_if) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_ack_dm) begin
                r_dm_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_dm_gnt    = r_dm_gnt;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: single transactions from a vector table,
// plus hand-written sequences for reset, simultaneous requests, spurious acks and starvation.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_gnt, dm_gnt, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] last_if, last_dm;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .i_dm_be(dm_be), .o_dm_gnt(dm_gnt), .o_dm_rdata(dm_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        mem_ack   = 1'b0;
        if_addr   = 32'h0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        dm_be     = 4'h0;
        mem_rdata = 32'h0BAD_0BAD;
    endtask

    task automatic check_all_zero(input string p);
        check({p, " mem_req"}, 32'(mem_req), 32'h0);
        check({p, " mem_we"}, 32'(mem_we), 32'h0);
        check({p, " mem_addr"}, mem_addr, 32'h0);
        check({p, " mem_wdata"}, mem_wdata, 32'h0);
        check({p, " mem_be"}, 32'(mem_be), 32'h0);
        check({p, " if_gnt"}, 32'(if_gnt), 32'h0);
        check({p, " dm_gnt"}, 32'(dm_gnt), 32'h0);
        check({p, " if_rdata"}, if_rdata, 32'h0);
        check({p, " dm_rdata"}, dm_rdata, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        dm_we    = v.we;
        dm_wdata = v.wdata;
        dm_be    = v.be;
        if (v.is_dm) begin
            dm_req  = 1'b1;
            dm_addr = v.addr;
            if_addr = 32'h5555_0000;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
            dm_addr = 32'hAAAA_0000;
        end
        step();
        // Drop and scramble requester inputs: the captured transaction must not move.
        if_req   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = ~dm_we;
        dm_addr  = ~dm_addr;
        if_addr  = ~if_addr;
        dm_wdata = ~dm_wdata;
        dm_be    = ~dm_be;
        for (int k = 0; k <= v.lat; k++) begin
            check($sformatf("%s busy%0d mem_req", p, k), 32'(mem_req), 32'h1);
            check($sformatf("%s busy%0d mem_we", p, k), 32'(mem_we), 32'(v.exp_we));
            check($sformatf("%s busy%0d mem_addr", p, k), mem_addr, v.addr);
            check($sformatf("%s busy%0d mem_wdata", p, k), mem_wdata, v.exp_wdata);
            check($sformatf("%s busy%0d mem_be", p, k), 32'(mem_be), 32'(v.exp_be));
            check($sformatf("%s busy%0d gnts", p, k), 32'({if_gnt, dm_gnt}), 32'h0);
            if (k == v.lat) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        if (v.is_dm) last_dm = v.rdata;
        else         last_if = v.rdata;
        check({p, " done gnts"}, 32'({if_gnt, dm_gnt}), v.is_dm ? 32'h1 : 32'h2);
        check({p, " done mem_req"}, 32'(mem_req), 32'h0);
        check({p, " done if_rdata"}, if_rdata, last_if);
        check({p, " done dm_rdata"}, dm_rdata, last_dm);
        step();
        check({p, " idle gnts"}, 32'({if_gnt, dm_gnt}), 32'h0);
        check({p, " idle dm_rdata"}, dm_rdata, last_dm);
        check({p, " idle if_rdata"}, if_rdata, last_if);
    endtask

    initial begin
        logic exp_if;
        int   w;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h2, 3, 32'h0051_3093, 1'b0, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 2, 32'hCAFE_0001, 1'b1, 4'h3, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0000_0000, 4'hF, 1, 32'h89AB_CDEF, 1'b0, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h0, 5, 32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'h0000_00A5, 4'h8, 0, 32'h0000_0000, 1'b1, 4'h8, 32'h0000_00A5};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst     = 1'b0;
        last_if = 32'h0;
        last_dm = 32'h0;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset held two cycles in the middle of a data transaction.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300; dm_wdata = 32'h1111_2222; dm_be = 4'hF;
        step();
        check("rstmid busy mem_req", 32'(mem_req), 32'h1);
        step();
        rst = 1'b1;
        dm_req = 1'b0;
        step();
        step();
        check_all_zero("rstmid");
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        check("late ack gnts", 32'({if_gnt, dm_gnt}), 32'h0);
        check("late ack mem_req", 32'(mem_req), 32'h0);
        check("late ack dm_rdata", dm_rdata, 32'h0);
        step();
        check("late ack gnts+1", 32'({if_gnt, dm_gnt}), 32'h0);
        if_req = 1'b1; if_addr = 32'h0000_0040;
        step();
        check("post-rst fetch mem_req", 32'(mem_req), 32'h1);
        check("post-rst fetch addr", mem_addr, 32'h0000_0040);
        if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h4040_4040;
        step();
        mem_ack = 1'b0;
        check("post-rst fetch gnt", 32'({if_gnt, dm_gnt}), 32'h2);
        check("post-rst fetch rdata", if_rdata, 32'h4040_4040);
        step();

        // Simultaneous requests: data first, then fetch with M+3 spacing.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_2000; dm_wdata = 32'h0F0F_0F0F; dm_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        step();
        check("simul first we", 32'(mem_we), 32'h1);
        check("simul first addr", mem_addr, 32'h0000_2000);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        step();
        mem_ack = 1'b0;
        check("simul dm gnts", 32'({if_gnt, dm_gnt}), 32'h1);
        check("simul dm rdata", dm_rdata, 32'hAAAA_0001);
        dm_req = 1'b0;
        step();
        check("simul M+2 gnts", 32'({if_gnt, dm_gnt}), 32'h0);
        check("simul M+2 mem_req", 32'(mem_req), 32'h0);
        step();
        check("simul M+3 mem_req", 32'(mem_req), 32'h1);
        check("simul second addr", mem_addr, 32'h0000_1000);
        check("simul second we", 32'(mem_we), 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002;
        step();
        mem_ack = 1'b0;
        check("simul if gnts", 32'({if_gnt, dm_gnt}), 32'h2);
        check("simul if rdata", if_rdata, 32'hBBBB_0002);
        if_req = 1'b0;
        step();
        check("simul end gnts", 32'({if_gnt, dm_gnt}), 32'h0);

        // Spurious ack in IDLE, then in DONE, with a back-to-back request.
        mem_ack = 1'b1; mem_rdata = 32'hEEEE_EEEE;
        step();
        mem_ack = 1'b0;
        check("spur idle gnts", 32'({if_gnt, dm_gnt}), 32'h0);
        check("spur idle mem_req", 32'(mem_req), 32'h0);
        check("spur idle dm_rdata", dm_rdata, 32'hAAAA_0001);
        check("spur idle if_rdata", if_rdata, 32'hBBBB_0002);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0500;
        step();
        check("spur dm mem_req", 32'(mem_req), 32'h1);
        dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5050_5050;
        step();
        check("spur dm gnt", 32'({if_gnt, dm_gnt}), 32'h1);
        check("spur dm rdata", dm_rdata, 32'h5050_5050);
        mem_rdata = 32'hEEEE_EEEE;
        dm_req = 1'b1; dm_addr = 32'h0000_0600;
        step();
        mem_ack = 1'b0;
        check("spur done gnts", 32'({if_gnt, dm_gnt}), 32'h0);
        check("spur done mem_req", 32'(mem_req), 32'h0);
        check("spur done dm_rdata", dm_rdata, 32'h5050_5050);
        step();
        check("b2b M+3 mem_req", 32'(mem_req), 32'h1);
        check("b2b M+3 addr", mem_addr, 32'h0000_0600);
        dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h6060_6060;
        step();
        mem_ack = 1'b0;
        check("b2b gnt", 32'({if_gnt, dm_gnt}), 32'h1);
        check("b2b rdata", dm_rdata, 32'h6060_6060);
        step();

        // Both requesters held high continuously.
        rst = 1'b1;
        step();
        rst = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        for (int t = 0; t < 10; t++) begin
            w = 0;
            while (mem_req !== 1'b1 && w < 6) begin
                step();
                w++;
            end
            check($sformatf("starve t%0d mem_req", t), 32'(mem_req), 32'h1);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = ((t % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            check($sformatf("starve t%0d addr", t), mem_addr, exp_if ? 32'h0000_1000 : 32'h0000_2000);
            mem_ack = 1'b1; mem_rdata = 32'(t);
            step();
            mem_ack = 1'b0;
            check($sformatf("starve t%0d gnts", t), 32'({if_gnt, dm_gnt}), exp_if ? 32'h2 : 32'h1);
            step();
        end

        idle_inputs();
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, 4, consecutive data grants allowed while fetch waits (guard only).
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_if_req  in  1  fetch request; held high until o_if_gnt.
REQ-007 i_if_addr  in  ADDR_W  fetch address.
REQ-008 o_if_gnt  out  1  one-cycle pulse; fetch complete.
REQ-009 o_if_rdata  out  DATA_W  fetch data, valid while o_if_gnt=1.
REQ-010 i_dm_req  in  1  data request; held high until o_dm_gnt.
REQ-011 i_dm_we / i_dm_addr / i_dm_wdata / i_dm_be  in  1/ADDR_W/DATA_W/DATA_W/8  data write-enable, address, write data, byte enables.
REQ-012 o_dm_gnt  out  1  one-cycle pulse; data access complete.
REQ-013 o_dm_rdata  out  DATA_W  load data, valid while o_dm_gnt=1.
REQ-014 o_mem_req / o_mem_we / o_mem_addr / o_mem_wdata / o_mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  shared memory port, all registered.
REQ-015 i_mem_ack  in  1  memory completion, one cycle, any latency >=1 after o_mem_req rises.
REQ-016 i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ack.

Function
REQ-017 FSM states IDLE, IF_BUSY, DM_BUSY, DONE; exactly one memory transaction outstanding.
REQ-018 IDLE: if i_dm_req=1 -> DM_BUSY; else if i_if_req=1 -> IF_BUSY; else stay (data has priority, subject to REQ-030).
REQ-019 On IDLE->x_BUSY, o_mem_* captured from the winning port; o_mem_req=1 from next cycle; fetch forces o_mem_we=0, o_mem_be=all ones, o_mem_wdata=0.
REQ-020 o_mem_* held stable throughout x_BUSY; requester input changes during BUSY are ignored.
REQ-021 x_BUSY with i_mem_ack=1 -> DONE; o_mem_req=0 and i_mem_rdata captured into o_x_rdata on that edge.
REQ-022 DONE lasts exactly one cycle: corresponding o_x_gnt=1, all requests ignored, then -> IDLE.
REQ-023 Latency: request seen in IDLE at cycle N -> o_mem_req=1 at N+1; ack at M -> gnt at M+1, IDLE at M+2, next o_mem_req earliest M+3.
REQ-024 o_if_gnt and o_dm_gnt never high together; never high outside DONE.
REQ-025 i_mem_ack in IDLE or DONE is ignored; no state change, no gnt.
REQ-026 Requester dropping req mid-transaction does not abort it; gnt still pulses.
REQ-027 o_x_rdata holds last captured value between grants; for a store, o_dm_rdata = i_mem_rdata at ack.

Reset
REQ-028 While i_rst=1 on a clock edge: state=IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, o_if_gnt=0, o_dm_gnt=0, o_if_rdata=0, o_dm_rdata=0, starvation counter=0.
REQ-029 Reset mid-transaction abandons it: no gnt issued, o_mem_req=0 the cycle after the reset edge; a late i_mem_ack is ignored per REQ-025.

Configuration
REQ-030 With MEM_ARB_STARVE_GUARD_EN defined: counter increments on each DM grant taken while i_if_req=1, clears on each IF grant; when counter=STARVE_MAX and both requests pending in IDLE, fetch wins.
REQ-031 Without MEM_ARB_STARVE_GUARD_EN: strict data priority; no counter logic; STARVE_MAX unused.

Verification
REQ-032 Reset: i_rst=1 two cycles during DM_BUSY -> all outputs 0, IDLE; i_mem_ack next cycle produces no gnt.
REQ-033 Fetch only: i_if_addr=0x0000_0010, ack 3 cycles after o_mem_req with rdata=0x0051_3093 -> o_mem_we=0, o_mem_be=0xF, o_if_gnt one cycle with o_if_rdata=0x0051_3093.
REQ-034 Store: we=1, addr=0x0000_0100, wdata=0xDEAD_BEEF, be=0x3 -> o_mem_* match exactly for whole BUSY; o_dm_gnt one cycle after ack.
REQ-035 Simultaneous requests same cycle -> DM served first, then IF; gnts in separate cycles, never together.
REQ-036 Guard on, STARVE_MAX=4, i_dm_req and i_if_req held high continuously, ack latency 1 -> grant order DM,DM,DM,DM,IF,repeat; guard off -> IF never granted while DM pending.
REQ-037 Spurious i_mem_ack in IDLE and DONE -> no gnt, no state change; back-to-back timing matches REQ-023.
